// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: word width, state
// encodings and the width of the access watchdog counter.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    // Watchdog counter width; covers terminal counts up to 255.
    localparam int TMO_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DREAD  = 3'd2;
    localparam logic [2:0] ST_DWRITE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        DREAD  = ST_DREAD,
        DWRITE = ST_DWRITE,
        DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Generic cycle watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count would reach TERMINAL.
module mem_timeout_counter #(
    parameter int TERMINAL = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    import mem_port_arbiter_pkg::*;

    logic [TMO_W-1:0] count;

    // Count enabled cycles, saturating so a stalled owner cannot wrap it.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TMO_W'(1);
        end
    end

    // tc is high during the TERMINAL-th enabled cycle so the owner can act on
    // the same edge that would make the count equal TERMINAL.
    assign tc = enable && (count == TMO_W'(TERMINAL - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single shared memory port between instruction fetch and
// data load/store with a req/done handshake, a bus-timeout watchdog and a
// completed-fetch counter.
module mem_port_arbiter #(
    parameter int WORD_SIZE      = mem_port_arbiter_pkg::WORD_SIZE,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FAIR           = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_done,
    output logic [WORD_SIZE-1:0] if_data,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic                 bus_err,
    output logic [WORD_SIZE-1:0] num_fetch
);
    import mem_port_arbiter_pkg::*;

    state_t               state;
    logic [WORD_SIZE-1:0] wdata;
    logic                 last_was_data;
    logic                 in_access;
    logic                 tmo_tc;
    logic                 pick_fetch;

    assign in_access = (state == FETCH) || (state == DREAD) || (state == DWRITE);

    // Fetch wins outright when alone; under contention only when fairness is
    // on and the previous grant went to data.
    assign pick_fetch = if_req && (!d_req || ((FAIR != 0) && last_was_data));

    // The store word is on the bus only while the write strobe is up.
    assign data = (state == DWRITE) ? wdata : {WORD_SIZE{1'bz}};

    mem_timeout_counter #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_access),
        .enable  (in_access),
        .tc      (tmo_tc)
    );

    // Port sequencer: grant, strobe, wait for response or timeout, turnaround.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            readM         <= 1'b0;
            writeM        <= 1'b0;
            address       <= '0;
            wdata         <= '0;
            if_done       <= 1'b0;
            if_data       <= '0;
            d_done        <= 1'b0;
            d_rdata       <= '0;
            bus_err       <= 1'b0;
            num_fetch     <= '0;
            last_was_data <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_fetch) begin
                        state         <= FETCH;
                        address       <= if_addr;
                        readM         <= 1'b1;
                        last_was_data <= 1'b0;
                    end else if (d_req) begin
                        address       <= d_addr;
                        last_was_data <= 1'b1;
                        if (d_we) begin
                            state  <= DWRITE;
                            writeM <= 1'b1;
                            wdata  <= d_wdata;
                        end else begin
                            state <= DREAD;
                            readM <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (inputReady) begin
                        if_data   <= data;
                        readM     <= 1'b0;
                        if_done   <= 1'b1;
                        num_fetch <= num_fetch + WORD_SIZE'(1);
                        state     <= DONE;
                    end else if (tmo_tc) begin
                        if_data <= '0;
                        readM   <= 1'b0;
                        if_done <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                DREAD: begin
                    if (inputReady) begin
                        d_rdata <= data;
                        readM   <= 1'b0;
                        d_done  <= 1'b1;
                        state   <= DONE;
                    end else if (tmo_tc) begin
                        d_rdata <= '0;
                        readM   <= 1'b0;
                        d_done  <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                DWRITE: begin
                    if (ackOutput) begin
                        writeM <= 1'b0;
                        d_done <= 1'b1;
                        state  <= DONE;
                    end else if (tmo_tc) begin
                        writeM  <= 1'b0;
                        d_done  <= 1'b1;
                        bus_err <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected results
// computed from a memory/latency model; a monitor pops and compares on done.
module tb_mem_port_arbiter;

    localparam int W       = 16;
    localparam int T       = 4;
    localparam int TB_FAIR = 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         if_req, d_req, d_we;
    logic [W-1:0] if_addr, d_addr, d_wdata;
    logic         if_done, d_done, readM, writeM, bus_err;
    logic [W-1:0] if_data, d_rdata, address, num_fetch;
    logic         inputReady, ackOutput;
    logic [W-1:0] mem_drv;
    wire  [W-1:0] data_bus;

    assign data_bus = readM ? mem_drv : {W{1'bz}};

    mem_port_arbiter #(
        .WORD_SIZE      (W),
        .TIMEOUT_CYCLES (T),
        .FAIR           (TB_FAIR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_data    (if_data),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data_bus),
        .inputReady (inputReady),
        .ackOutput  (ackOutput),
        .bus_err    (bus_err),
        .num_fetch  (num_fetch)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] val;
        int           len;
        bit           tmo;
        bit           st;
        logic [W-1:0] nf;
    } exp_t;

    exp_t         if_q[$];
    exp_t         d_q[$];
    int           gr[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] mem[int];
    logic [W-1:0] ref_mem[int];
    logic [W-1:0] fcnt = '0;
    bit           any_tmo = 1'b0;
    logic [W-1:0] last_wr = '0;

    function automatic logic [W-1:0] init_word(input logic [W-1:0] a);
        logic [W-1:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    function automatic logic [W-1:0] dev_rd(input logic [W-1:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    // Cycles the memory waits after the strobe rises before responding.
    function automatic int lat_of(input logic [W-1:0] a);
        logic [3:0] i;
        i = a[3:0] ^ a[11:8];
        if (i == 4'hF) return T + 5;
        if (i == 4'hE) return T - 1;
        return int'(i) % T;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic build_exp(input logic [W-1:0] a, input bit st, input logic [W-1:0] wd,
                             input bit is_fetch, output exp_t e);
        int l;
        l     = lat_of(a);
        e.tmo = (l >= T);
        e.len = e.tmo ? T : l + 1;
        e.st  = st;
        if (st) begin
            e.val = wd;
            if (!e.tmo) ref_mem[int'(a)] = wd;
        end else begin
            e.val = e.tmo ? '0 : ref_rd(a);
        end
        if (is_fetch && !e.tmo) fcnt = fcnt + 16'd1;
        e.nf = fcnt;
        if (e.tmo) any_tmo = 1'b1;
    endtask

    task automatic wait_done(input bit dat, input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (dat ? d_done : if_done) break;
        end
        chk(nm, (k < 200), 1);
    endtask

    task automatic do_fetch(input logic [W-1:0] a);
        exp_t e;
        if_addr = a;
        if_req  = 1'b1;
        build_exp(a, 1'b0, '0, 1'b1, e);
        if_q.push_back(e);
        wait_done(1'b0, "if_done_wait");
        if_req = 1'b0;
    endtask

    task automatic do_data(input bit we, input logic [W-1:0] a, input logic [W-1:0] wd);
        exp_t e;
        d_addr  = a;
        d_we    = we;
        d_wdata = wd;
        d_req   = 1'b1;
        build_exp(a, we, wd, 1'b0, e);
        d_q.push_back(e);
        wait_done(1'b1, "d_done_wait");
        d_req = 1'b0;
    endtask

    // Memory device: responds after lat_of(address) strobe cycles.
    initial begin
        int cnt;
        cnt = 0;
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        mem_drv    = '0;
        forever begin
            @(negedge clk);
            inputReady = 1'b0;
            ackOutput  = 1'b0;
            if (readM || writeM) begin
                if (cnt == lat_of(address)) begin
                    if (readM) begin
                        mem_drv    = dev_rd(address);
                        inputReady = 1'b1;
                    end else begin
                        mem[int'(address)] = data_bus;
                        last_wr            = data_bus;
                        ackOutput          = 1'b1;
                    end
                end
                cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a done pulse appears.
    initial begin
        int   len;
        bit   pi, pd, prs, pws;
        exp_t e;
        len = 0; pi = 0; pd = 0; prs = 0; pws = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                len = 0; pi = 0; pd = 0; prs = 0; pws = 0;
            end else begin
                if (readM && writeM) chk("strobe_exclusive", 32'(readM & writeM), 0);
                if (writeM && !pws) gr.push_back(1);
                if (readM && !prs) gr.push_back(0);
                if (readM || writeM) len++;
                if (if_done) begin
                    if (if_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL if_spurious: got if_done=1, expected no fetch pending");
                    end else begin
                        e = if_q.pop_front();
                        chk("if_data", if_data, e.val);
                        chk("num_fetch", num_fetch, e.nf);
                        chk("if_strobe_len", len, e.len);
                        chk("if_single_pulse", pi, 0);
                        if (e.tmo) chk("if_bus_err", bus_err, 1);
                    end
                    len = 0;
                end
                if (d_done) begin
                    if (d_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL d_spurious: got d_done=1, expected no data pending");
                    end else begin
                        e = d_q.pop_front();
                        if (e.st) begin
                            if (!e.tmo) chk("store_bus_word", last_wr, e.val);
                        end else begin
                            chk("d_rdata", d_rdata, e.val);
                        end
                        chk("d_strobe_len", len, e.len);
                        chk("d_single_pulse", pd, 0);
                        if (e.tmo) chk("d_bus_err", bus_err, 1);
                    end
                    len = 0;
                end
                pi = if_done; pd = d_done; prs = readM; pws = writeM;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by a randomized two-requester run.
    initial begin
        int dones;
        int exp_gr[4];
        exp_t e;
        reset_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        mem[16'h0010]     = 16'h6000;
        ref_mem[16'h0010] = 16'h6000;
        repeat (3) @(negedge clk);
        chk("rst_readM", readM, 0);
        chk("rst_writeM", writeM, 0);
        chk("rst_address", address, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_num_fetch", num_fetch, 0);
        reset_n = 1'b1;
        @(negedge clk);

        do_fetch(16'h0010);
        do_data(1'b1, 16'h0200, 16'hBEEF);
        do_data(1'b0, 16'h0200, 16'h0000);
        do_data(1'b0, 16'h800F, 16'h0000);
        repeat (3) @(negedge clk);
        chk("bus_err_sticky", bus_err, 1);

        if_addr = 16'h001F;
        if_req  = 1'b1;
        repeat (3) @(negedge clk);
        chk("midfetch_readM_up", readM, 1);
        reset_n = 1'b0;
        if_req  = 1'b0;
        @(negedge clk);
        chk("midfetch_readM", readM, 0);
        chk("midfetch_if_done", if_done, 0);
        chk("midfetch_num_fetch", num_fetch, 0);
        chk("midfetch_bus_err", bus_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        fcnt    = '0;
        any_tmo = 1'b0;
        @(negedge clk);
        do_fetch(16'h0010);

        exp_gr = '{1, 0, 1, 0};
        gr.delete();
        if_addr = 16'h0010;
        d_addr  = 16'h8001;
        d_we    = 1'b1;
        d_wdata = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            build_exp(16'h8001, 1'b1, 16'h1234, 1'b0, e);
            d_q.push_back(e);
            build_exp(16'h0010, 1'b0, '0, 1'b1, e);
            if_q.push_back(e);
        end
        if_req = 1'b1;
        d_req  = 1'b1;
        dones  = 0;
        for (int k = 0; k < 200 && dones < 4; k++) begin
            @(negedge clk);
            dones += int'(if_done) + int'(d_done);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("contention_dones", dones, 4);
        chk("contention_grants", gr.size(), 4);
        for (int i = 0; i < 4 && i < gr.size(); i++) chk("grant_order", gr[i], exp_gr[i]);

        @(negedge clk);
        force dut.num_fetch = 16'hFFFF;
        #1;
        release dut.num_fetch;
        fcnt = 16'hFFFF;
        @(negedge clk);
        do_fetch(16'h0010);

        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    do_fetch(16'($urandom_range(0, 16'h7FFF)));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    do_data(1'($urandom_range(0, 1)), 16'h8000 | 16'($urandom_range(0, 63)),
                            16'($urandom));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        join

        repeat (5) @(negedge clk);
        chk("if_queue_drained", if_q.size(), 0);
        chk("d_queue_drained", d_q.size(), 0);
        chk("bus_err_final", bus_err, 32'(any_tmo));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
